// File: rtl/pipe_ctrl_if.sv
// Signal bundle between pipe_ctrl (master) and the hazard/branch/memory logic
// plus the pipeline registers it steers (slave).
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hazard;
    logic             ex_branch_taken;
    logic             id_jump;
    logic             dmem_req;
    logic             dmem_ready;
    logic             halt_req;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        input  hazard, ex_branch_taken, id_jump, dmem_req, dmem_ready, halt_req,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
        output halted, mem_timeout, stall_count
    );

    modport slave (
        output hazard, ex_branch_taken, id_jump, dmem_req, dmem_ready, halt_req,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
        input  halted, mem_timeout, stall_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns hazard, redirect, dmem-wait and halt
// events into per-stage enables/flushes, PC write enable and a stall counter.
module pipe_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         reset,
    pipe_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BUBBLE  = 2'd1,
        MEMWAIT = 2'd2,
        HALTED  = 2'd3
    } state_e;

    // Control word: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    localparam logic [6:0] CTL_ADV = 7'b1101011;
    localparam logic [6:0] CTL_FRZ = 7'b0000000;
    localparam logic [6:0] CTL_BUB = 7'b0001111;
    localparam logic [6:0] CTL_BR  = 7'b1111111;
    localparam logic [6:0] CTL_JMP = 7'b1111011;
    localparam logic [6:0] CTL_RST = 7'b0010100;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    state_e           ret_state_q, ret_state_d;
    state_e           dec_state_s;
    logic [1:0]       bubble_cnt_q, bubble_cnt_d;
    logic [1:0]       ret_bubble_q, ret_bubble_d;
    logic [1:0]       dec_bcnt_s;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_count_q;
    logic [6:0]       ctl_s;
    logic [6:0]       ctl_out_s;
    logic             mem_stall_s;
    logic             allow_memwait_s;
    logic             do_decode_s;

    // Next-state and control-word decode
    always_comb begin
        state_d         = state_q;
        ret_state_d     = ret_state_q;
        bubble_cnt_d    = bubble_cnt_q;
        ret_bubble_d    = ret_bubble_q;
        wait_cnt_d      = wait_cnt_q;
        mem_timeout_d   = mem_timeout_q;
        ctl_s           = CTL_FRZ;
        do_decode_s     = 1'b0;
        mem_stall_s     = bus.dmem_req && !bus.dmem_ready;
        allow_memwait_s = (state_q != MEMWAIT);

        // Returning from a memory wait replays the saved state's decode.
        if (state_q == MEMWAIT) begin
            dec_state_s = ret_state_q;
            dec_bcnt_s  = ret_bubble_q;
        end else begin
            dec_state_s = state_q;
            dec_bcnt_s  = bubble_cnt_q;
        end

        case (state_q)
            RUN:     do_decode_s = 1'b1;
            BUBBLE:  do_decode_s = 1'b1;
            MEMWAIT: begin
                if (bus.dmem_ready) begin
                    do_decode_s = 1'b1;
                end else if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
                    state_d       = HALTED;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            HALTED:  ctl_s = CTL_FRZ;
            default: ctl_s = CTL_FRZ;
        endcase

        if (do_decode_s) begin
            if (allow_memwait_s && mem_stall_s) begin
                ctl_s      = CTL_FRZ;
                state_d    = MEMWAIT;
                wait_cnt_d = 8'd1;
                if (dec_state_s == BUBBLE) begin
                    ret_state_d  = BUBBLE;
                    ret_bubble_d = bubble_cnt_q;
                end else begin
                    ret_state_d  = RUN;
                    ret_bubble_d = 2'd0;
                end
            end else if (dec_state_s == BUBBLE) begin
                ctl_s        = CTL_BUB;
                bubble_cnt_d = dec_bcnt_s - 2'd1;
                state_d      = (dec_bcnt_s == 2'd1) ? RUN : BUBBLE;
            end else if (bus.ex_branch_taken) begin
                ctl_s   = CTL_BR;
                state_d = RUN;
            end else if (bus.hazard) begin
                ctl_s = CTL_BUB;
                if (STALL_CYCLES > 1) begin
                    state_d      = BUBBLE;
                    bubble_cnt_d = 2'(STALL_CYCLES - 1);
                end else begin
                    state_d = RUN;
                end
            end else if (bus.id_jump) begin
                ctl_s   = CTL_JMP;
                state_d = RUN;
            end else if (bus.halt_req) begin
                ctl_s   = CTL_ADV;
                state_d = HALTED;
            end else begin
                ctl_s   = CTL_ADV;
                state_d = RUN;
            end
        end else begin
            ctl_s = CTL_FRZ;
        end

        if (reset) begin
            ctl_out_s = CTL_RST;
        end else begin
            ctl_out_s = ctl_s;
        end
    end

    // State, saved context, sticky timeout and stall counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            ret_state_q   <= RUN;
            bubble_cnt_q  <= 2'd0;
            ret_bubble_q  <= 2'd0;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            ret_state_q   <= ret_state_d;
            bubble_cnt_q  <= bubble_cnt_d;
            ret_bubble_q  <= ret_bubble_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            if (!ctl_s[6] && (state_q != HALTED) && (stall_count_q != CNT_MAX)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en       = ctl_out_s[6];
    assign bus.ifid_en     = ctl_out_s[5];
    assign bus.ifid_flush  = ctl_out_s[4];
    assign bus.idex_en     = ctl_out_s[3];
    assign bus.idex_flush  = ctl_out_s[2];
    assign bus.exmem_en    = ctl_out_s[1];
    assign bus.memwb_en    = ctl_out_s[0];
    assign bus.halted      = (state_q == HALTED);
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.stall_count = stall_count_q;
endmodule
